// File: rtl/program_memory_loader.sv
// Writable instruction memory with a valid/ready byte-stream loader and a core fetch port.
// Define PROGMEM_CHECKSUM_EN to treat the load_last word as a checksum instead of a program word.
module program_memory_loader #(
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned READ_LATENCY = 0
) (
   input  logic              program_clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              core_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   load_count
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   typedef enum logic [1:0] {StIdle, StLoad, StFinish} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                error_q, error_d;
   logic                mem_we;
   logic                cks_word;
   logic                cks_bad;
   logic [DATA_W-1:0]   mem [Depth];

`ifdef PROGMEM_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d, sum_total;

   assign sum_total = sum_q + load_data;
   assign cks_word  = load_last;
   assign cks_bad   = |sum_total;

   always_comb begin
      sum_d = sum_q;
      if (state_q == StIdle && load_start) begin
         sum_d = '0;
      end else if (mem_we) begin
         sum_d = sum_total;
      end
   end

   always_ff @(posedge program_clk) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end
`else
   assign cks_word = 1'b0;
   assign cks_bad  = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      error_d    = error_q;
      mem_we     = 1'b0;
      load_ready = 1'b0;
      core_hold  = 1'b0;
      load_done  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load_start) begin
               state_d = StLoad;
               ptr_d   = load_base;
               count_d = '0;
               error_d = 1'b0;
            end
         end
         StLoad: begin
            load_ready = 1'b1;
            core_hold  = 1'b1;
            if (load_valid) begin
               if (cks_word) begin
                  state_d = StFinish;
                  error_d = cks_bad;
               end else begin
                  mem_we  = 1'b1;
                  count_d = count_q + 1'b1;
                  if (load_last) begin
                     state_d = StFinish;
                  end else if (&ptr_q) begin
                     // Top of memory reached without load_last: stop rather than wrap.
                     state_d = StFinish;
                     error_d = 1'b1;
                  end else begin
                     ptr_d = ptr_q + 1'b1;
                  end
               end
            end
         end
         StFinish: begin
            load_done = 1'b1;
            core_hold = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge program_clk) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   // Memory contents survive reset; only the write itself is suppressed.
   always_ff @(posedge program_clk) begin
      if (mem_we && !reset) begin
         mem[ptr_q] <= load_data;
      end
   end

   generate
      if (READ_LATENCY == 0) begin : g_comb_read
         assign fetch_data = mem[fetch_addr];
      end else begin : g_reg_read
         logic [DATA_W-1:0] fetch_q;
         always_ff @(posedge program_clk) begin
            if (reset) begin
               fetch_q <= '0;
            end else begin
               fetch_q <= mem[fetch_addr];
            end
         end
         assign fetch_data = fetch_q;
      end
   endgenerate

   assign load_error = error_q;
   assign load_count = count_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Bench for program_memory_loader: combinational and registered-read instances share one stimulus
// stream and are checked every cycle against a behavioural model of the loader and memory.
module tb_program_memory_loader;

   logic       clk = 1'b0;
   logic       rst, ls, lv, ll;
   logic [7:0] fa, lb, ld;
   logic [7:0] f0, f1;
   logic       rdy0, rdy1, hold0, hold1, done0, done1, err0, err1;
   logic [8:0] cnt0, cnt1;

`ifdef PROGMEM_CHECKSUM_EN
   localparam bit CksEn = 1'b1;
`else
   localparam bit CksEn = 1'b0;
`endif

   int npass  = 0;
   int ntotal = 0;

   program_memory_loader #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(0)) dut0 (
      .program_clk(clk), .reset(rst), .fetch_addr(fa), .fetch_data(f0),
      .load_start(ls), .load_base(lb), .load_valid(lv), .load_data(ld), .load_last(ll),
      .load_ready(rdy0), .core_hold(hold0), .load_done(done0), .load_error(err0),
      .load_count(cnt0)
   );

   program_memory_loader #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(1)) dut1 (
      .program_clk(clk), .reset(rst), .fetch_addr(fa), .fetch_data(f1),
      .load_start(ls), .load_base(lb), .load_valid(lv), .load_data(ld), .load_last(ll),
      .load_ready(rdy1), .core_hold(hold1), .load_done(done1), .load_error(err1),
      .load_count(cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      ntotal++;
      if (act == exp) npass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural model: memory image with known-flags plus loader status.
   int  mm [256];
   bit  kn [256];
   bit  mvalid = 1'b0;
   bit  mload, mfin, merr;
   int  mptr, mcnt, msum;
   int  e1;
   bit  k1 = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         mvalid = 1'b1; mload = 1'b0; mfin = 1'b0; merr = 1'b0;
         mptr = 0; mcnt = 0; msum = 0; e1 = 0; k1 = 1'b1;
      end else if (mvalid) begin
         e1 = mm[fa];
         k1 = kn[fa];
         if (mfin) begin
            mfin = 1'b0;
         end else if (!mload) begin
            if (ls) begin
               mload = 1'b1; mptr = lb; mcnt = 0; merr = 1'b0; msum = 0;
            end
         end else if (lv) begin
            if (CksEn && ll) begin
               if ((msum + ld) % 256 != 0) merr = 1'b1;
               mload = 1'b0; mfin = 1'b1;
            end else begin
               mm[mptr] = ld; kn[mptr] = 1'b1;
               mcnt++;
               msum = (msum + ld) % 256;
               if (ll) begin
                  mload = 1'b0; mfin = 1'b1;
               end else if (mptr == 255) begin
                  merr = 1'b1; mload = 1'b0; mfin = 1'b1;
               end else begin
                  mptr++;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("ready0", rdy0, mload);
         chk("ready1", rdy1, mload);
         chk("hold0", hold0, mload || mfin);
         chk("hold1", hold1, mload || mfin);
         chk("done0", done0, mfin);
         chk("done1", done1, mfin);
         chk("error0", err0, merr);
         chk("error1", err1, merr);
         chk("count0", cnt0, mcnt);
         chk("count1", cnt1, mcnt);
         if (kn[fa]) chk("fetch0", f0, mm[fa]);
         if (k1) chk("fetch1", f1, e1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start(input logic [7:0] base);
      ls = 1'b1; lb = base;
      tick();
      ls = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      int n = 0;
      lv = 1'b1; ld = d; ll = last;
      while (1) begin
         @(negedge clk);
         if (rdy0) break;
         n++;
         if (n > 20) begin
            chk("send_timeout", 0, 1);
            break;
         end
      end
      tick();
      lv = 1'b0; ll = 1'b0;
   endtask

   // Streams n program words; in checksum builds a balancing checksum word is appended.
   task automatic load_words(input logic [7:0] base, input logic [7:0] w [4], input int n,
                             input bit gap);
      logic [7:0] s = 8'd0;
      logic [7:0] c;
      start(base);
      for (int i = 0; i < n; i++) begin
         if (gap && i > 0) tick();
         send(w[i], (i == n - 1) && !CksEn);
         s += w[i];
      end
      if (CksEn) begin
         c = 8'd0 - s;
         send(c, 1'b1);
      end
   endtask

   task automatic read_check(input logic [7:0] a, input logic [7:0] exp);
      fa = a;
      @(negedge clk);
      chk("read_comb", f0, exp);
      @(negedge clk);
      chk("read_reg", f1, exp);
      tick();
   endtask

   logic [7:0] w [4];

   initial begin
      rst = 1'b1; ls = 1'b0; lb = 8'd0; lv = 1'b0; ld = 8'd0; ll = 1'b0; fa = 8'd0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_ready", rdy0, 0);
      chk("rst_hold", hold0, 0);
      chk("rst_done", done0, 0);
      chk("rst_error", err0, 0);
      chk("rst_count", cnt0, 0);
      chk("rst_fetch_reg", f1, 0);
      tick();
      rst = 1'b0;

      w = '{8'h80, 8'h00, 8'h81, 8'h00};
      load_words(8'd0, w, 4, 1'b0);
      tick();
      read_check(8'd0, 8'h80);
      read_check(8'd1, 8'h00);
      read_check(8'd2, 8'h81);
      read_check(8'd3, 8'h00);

      w = '{8'hAA, 8'hBB, 8'hCC, 8'h00};
      load_words(8'd10, w, 3, 1'b1);
      @(negedge clk);
      chk("gap_done_pulse", done0, 1);
      chk("gap_hold_finish", hold0, 1);
      chk("gap_count", cnt0, 3);
      tick();
      @(negedge clk);
      chk("gap_done_clear", done0, 0);
      chk("gap_hold_clear", hold0, 0);
      tick();
      read_check(8'd10, 8'hAA);
      read_check(8'd11, 8'hBB);
      read_check(8'd12, 8'hCC);

      start(8'd254);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      @(negedge clk);
      chk("ovf_error", err0, 1);
      chk("ovf_done", done0, 1);
      tick();
      lv = 1'b1; ld = 8'h03; ll = 1'b0;
      tick();
      tick();
      lv = 1'b0;
      @(negedge clk);
      chk("ovf_idle_ready", rdy0, 0);
      chk("ovf_idle_hold", hold0, 0);
      chk("ovf_error_sticky", err0, 1);
      chk("ovf_count", cnt0, 2);
      tick();
      read_check(8'd0, 8'h80);
      read_check(8'd254, 8'h01);
      read_check(8'd255, 8'h02);

      w = '{8'h11, 8'h00, 8'h00, 8'h00};
      load_words(8'd5, w, 1, 1'b0);
      tick();
      tick();
      fa = 8'd5;
      start(8'd5);
      send(8'h42, !CksEn);
      @(negedge clk);
      chk("rf_old_word", f1, 8'h11);
      chk("rf_comb_new", f0, 8'h42);
      tick();
      @(negedge clk);
      chk("rf_new_word", f1, 8'h42);
      tick();
      if (CksEn) send(8'hBE, 1'b1);
      tick();
      tick();

      start(8'd20);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      rst = 1'b1; lv = 1'b1; ld = 8'h03;
      tick();
      rst = 1'b0; lv = 1'b0;
      @(negedge clk);
      chk("rstmid_ready", rdy0, 0);
      chk("rstmid_hold", hold0, 0);
      chk("rstmid_error", err0, 0);
      chk("rstmid_count", cnt0, 0);
      tick();
      read_check(8'd20, 8'h01);
      read_check(8'd21, 8'h02);

`ifdef PROGMEM_CHECKSUM_EN
      start(8'd40);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'hFD, 1'b1);
      @(negedge clk);
      chk("cks_good_error", err0, 0);
      chk("cks_good_count", cnt0, 2);
      tick();
      tick();
      start(8'd40);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'hFE, 1'b1);
      @(negedge clk);
      chk("cks_bad_error", err0, 1);
      chk("cks_bad_count", cnt0, 2);
      tick();
      tick();
`endif

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         rst = ($urandom_range(0, 199) == 0);
         ls  = ($urandom_range(0, 15) == 0);
         lb  = ($urandom_range(0, 3) == 0) ? 8'(250 + $urandom_range(0, 5))
                                            : 8'($urandom_range(0, 255));
         lv  = $urandom_range(0, 1) == 1;
         ld  = 8'($urandom_range(0, 255));
         ll  = ($urandom_range(0, 7) == 0);
         fa  = 8'($urandom_range(0, 255));
      end
      rst = 1'b0; ls = 1'b0; lv = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
